// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : imm_decode_stage
//  Purpose  : Pipelined immediate extraction for the decode path. It decodes
//             the format from the raw opcode and produces a sign- or
//             zero-extended XLEN-bit immediate, a format code and an illegal
//             flag. There is one cycle of latency, a valid/ready handshake on
//             both sides, an optional skid buffer and a flush input.
//  Ports    : clk, rst_n (synchronous, active low), flush_i
//             in_valid / in_ready / in_instr[31:0] / in_tag[TAG_W-1:0]
//             out_valid / out_ready / out_imm[XLEN-1:0] / out_fmt[2:0]
//             out_illegal / out_tag[TAG_W-1:0]
//  Revision : 1.0  initial release
// ============================================================================
module imm_decode_stage #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 8,
  parameter int SKID_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] c_FMT_R   = 3'd0;
  localparam logic [2:0] c_FMT_I   = 3'd1;
  localparam logic [2:0] c_FMT_S   = 3'd2;
  localparam logic [2:0] c_FMT_B   = 3'd3;
  localparam logic [2:0] c_FMT_U   = 3'd4;
  localparam logic [2:0] c_FMT_J   = 3'd5;
  localparam logic [2:0] c_FMT_SH  = 3'd6;
  localparam logic [2:0] c_FMT_ILL = 3'd7;

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_MISC   = 7'b0001111;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_OP32   = 7'b0111011;

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // --------------------------------------------------------------------------
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_shift;
  logic [XLEN-1:0] w_sext;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;

  assign w_opcode   = in_instr[6:0];
  assign w_funct3   = in_instr[14:12];
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
  assign w_sext     = {XLEN{in_instr[31]}};

  // Sign-extended formats start from an all-sign vector and overwrite the low
  // bits, so the same code works for both XLEN values.
  always_comb begin
    w_imm = '0;
    w_fmt = c_FMT_ILL;
    case (w_opcode)
      c_OP_LUI, c_OP_AUIPC: begin
        w_imm        = w_sext;
        w_imm[31:0]  = {in_instr[31:12], 12'b0};
        w_fmt        = c_FMT_U;
      end
      c_OP_JAL: begin
        w_imm        = w_sext;
        w_imm[20:0]  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        w_fmt        = c_FMT_J;
      end
      c_OP_BRANCH: begin
        w_imm        = w_sext;
        w_imm[12:0]  = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        w_fmt        = c_FMT_B;
      end
      c_OP_STORE: begin
        w_imm        = w_sext;
        w_imm[11:0]  = {in_instr[31:25], in_instr[11:7]};
        w_fmt        = c_FMT_S;
      end
      c_OP_JALR, c_OP_LOAD, c_OP_MISC: begin
        w_imm        = w_sext;
        w_imm[11:0]  = in_instr[31:20];
        w_fmt        = c_FMT_I;
      end
      c_OP_IMM: begin
        if (w_is_shift) begin
          // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one.
          if (XLEN == 64) w_imm[5:0] = in_instr[25:20];
          else            w_imm[4:0] = in_instr[24:20];
          w_fmt = c_FMT_SH;
        end else begin
          w_imm       = w_sext;
          w_imm[11:0] = in_instr[31:20];
          w_fmt       = c_FMT_I;
        end
      end
      c_OP_IMM32: begin
        if (XLEN == 64) begin
          if (w_is_shift) begin
            w_imm[4:0] = in_instr[24:20];
            w_fmt      = c_FMT_SH;
          end else begin
            w_imm       = w_sext;
            w_imm[11:0] = in_instr[31:20];
            w_fmt       = c_FMT_I;
          end
        end
      end
      c_OP_SYSTEM: begin
        // CSR address is an unsigned index, never sign-extended.
        w_imm[11:0] = in_instr[31:20];
        w_fmt       = c_FMT_I;
      end
      c_OP_OP: begin
        w_fmt = c_FMT_R;
      end
      c_OP_OP32: begin
        if (XLEN == 64) w_fmt = c_FMT_R;
      end
      default: begin
        w_fmt = c_FMT_ILL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output register plus optional skid entry
  // --------------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  logic [2:0]       out_fmt_q,   out_fmt_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,  skid_imm_d;
  logic [2:0]       skid_fmt_q,  skid_fmt_d;
  logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;
  logic             in_ready_q,  in_ready_d;

  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_out_free;

  if (SKID_EN != 0) begin : g_skid_ready
    assign w_in_ready = in_ready_q;
  end else begin : g_comb_ready
    assign w_in_ready = ~out_valid_q | out_ready;
  end

  // A flushed cycle never accepts, even if in_ready is high.
  assign w_in_fire  = in_valid & w_in_ready & ~flush_i;
  assign w_out_fire = out_valid_q & out_ready;
  assign w_out_free = ~out_valid_q | w_out_fire;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_tag_d   = skid_tag_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_out_free) begin
      if (skid_valid_q) begin
        // Older skid entry advances first to keep order.
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = w_in_fire;
        if (w_in_fire) begin
          skid_imm_d = w_imm;
          skid_fmt_d = w_fmt;
          skid_tag_d = in_tag;
        end
      end else begin
        out_valid_d = w_in_fire;
        if (w_in_fire) begin
          out_imm_d = w_imm;
          out_fmt_d = w_fmt;
          out_tag_d = in_tag;
        end
      end
    end else if (w_in_fire) begin
      // Output is stalled: only reachable with the skid buffer enabled.
      skid_valid_d = 1'b1;
      skid_imm_d   = w_imm;
      skid_fmt_d   = w_fmt;
      skid_tag_d   = in_tag;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= '0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= '0;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = (out_fmt_q == c_FMT_ILL);
  assign out_tag     = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_decode_stage
//  Purpose  : Self-checking bench for imm_decode_stage. An XLEN=32 and an
//             XLEN=64 instance share the same stimulus, and each has its own
//             expected-result queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_decode_stage;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [7:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        ir32, ov32, ill32, ir64, ov64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [7:0]  tag32, tag64;

  logic        ir  [2];
  logic        ov  [2];
  logic        ill [2];
  logic [63:0] oimm[2];
  logic [2:0]  ofmt[2];
  logic [7:0]  otag[2];

  assign ir[0] = ir32;  assign ir[1] = ir64;
  assign ov[0] = ov32;  assign ov[1] = ov64;
  assign ill[0] = ill32; assign ill[1] = ill64;
  assign oimm[0] = {32'b0, imm32}; assign oimm[1] = imm64;
  assign ofmt[0] = fmt32; assign ofmt[1] = fmt64;
  assign otag[0] = tag32; assign otag[1] = tag64;

  imm_decode_stage #(.XLEN(32), .TAG_W(8), .SKID_EN(1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(ir32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
    .out_illegal(ill32), .out_tag(tag32)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(8), .SKID_EN(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(ir64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64), .out_tag(tag64)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] delivered[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference decoder, written from the instruction-format definitions.
  function automatic exp_t model(input logic [31:0] ins, input bit x64, input logic [7:0] tag);
    exp_t r;
    logic signed [63:0] v;
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    logic signed [20:0] s21;
    logic signed [31:0] s32;
    logic [2:0] f3;
    f3 = ins[14:12];
    v = 0;
    r.fmt = 3'd7;
    case (ins[6:0])
      7'h37, 7'h17: begin s32 = {ins[31:12], 12'b0}; v = s32; r.fmt = 3'd4; end
      7'h6F: begin s21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; v = s21; r.fmt = 3'd5; end
      7'h63: begin s13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; v = s13; r.fmt = 3'd3; end
      7'h23: begin s12 = {ins[31:25], ins[11:7]}; v = s12; r.fmt = 3'd2; end
      7'h67, 7'h03, 7'h0F: begin s12 = ins[31:20]; v = s12; r.fmt = 3'd1; end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          v = x64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
          r.fmt = 3'd6;
        end else begin s12 = ins[31:20]; v = s12; r.fmt = 3'd1; end
      end
      7'h1B: begin
        if (x64) begin
          if (f3 == 3'd1 || f3 == 3'd5) begin v = 64'(ins[24:20]); r.fmt = 3'd6; end
          else begin s12 = ins[31:20]; v = s12; r.fmt = 3'd1; end
        end
      end
      7'h73: begin v = 64'(ins[31:20]); r.fmt = 3'd1; end
      7'h33: r.fmt = 3'd0;
      7'h3B: if (x64) r.fmt = 3'd0;
      default: r.fmt = 3'd7;
    endcase
    r.imm = x64 ? v : {32'b0, v[31:0]};
    r.tag = tag;
    return r;
  endfunction

  // Scoreboard: compares every held entry each cycle, then advances the model
  // according to the handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        int   sz;
        exp_t e;
        sz = (i == 0) ? q0.size() : q1.size();
        chk($sformatf("out_valid_x%0d", i), 64'(ov[i]), 64'(sz > 0));
        chk($sformatf("in_ready_x%0d", i), 64'(ir[i]), 64'(sz < 2));
        if (ov[i] && sz > 0) begin
          e = (i == 0) ? q0[0] : q1[0];
          chk($sformatf("imm_x%0d", i), oimm[i], e.imm);
          chk($sformatf("fmt_x%0d", i), 64'(ofmt[i]), 64'(e.fmt));
          chk($sformatf("illegal_x%0d", i), 64'(ill[i]), 64'(e.fmt == 3'd7));
          chk($sformatf("tag_x%0d", i), 64'(otag[i]), 64'(e.tag));
        end
        if (!rst_n || flush_i) begin
          if (i == 0) q0.delete(); else q1.delete();
        end else begin
          if (ov[i] && out_ready && sz > 0) begin
            if (i == 0) begin delivered.push_back(otag[0]); void'(q0.pop_front()); end
            else void'(q1.pop_front());
          end
          if (in_valid && ir[i]) begin
            if (i == 0) q0.push_back(model(in_instr, 1'b0, in_tag));
            else        q1.push_back(model(in_instr, 1'b1, in_tag));
          end
        end
      end
    end
  end

  logic [6:0] ops[16] = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h67, 7'h03, 7'h0F,
                          7'h13, 7'h1B, 7'h73, 7'h33, 7'h3B, 7'h7F, 7'h00, 7'h5B};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    r[6:0] = ops[$urandom_range(0, 15)];
    return r;
  endfunction

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    chk("drain_q32", 64'(q0.size()), 64'd0);
    chk("drain_q64", 64'(q1.size()), 64'd0);
    #1;
  endtask

  task automatic push_one(input logic [7:0] t);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00100093;
    in_tag   = t;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (ir[0]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("push_accept", 64'(done), 64'd1);
  endtask

  task automatic direct(input string name, input logic [31:0] ins,
                        input logic [63:0] e32, input logic [63:0] e64,
                        input logic [2:0] f32, input logic [2:0] f64);
    in_valid  = 1'b1;
    in_instr  = ins;
    in_tag    = 8'hA5;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid32"}, 64'(ov32), 64'd1);
    chk({name, "_imm32"}, 64'(imm32), e32);
    chk({name, "_fmt32"}, 64'(fmt32), 64'(f32));
    chk({name, "_ill32"}, 64'(ill32), 64'(f32 == 3'd7));
    chk({name, "_valid64"}, 64'(ov64), 64'd1);
    chk({name, "_imm64"}, imm64, e64);
    chk({name, "_fmt64"}, 64'(fmt64), 64'(f64));
    chk({name, "_ill64"}, 64'(ill64), 64'(f64 == 3'd7));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_valid"}, {62'b0, ov32, ov64}, 64'd0);
    chk({name, "_imm"}, imm64 | {32'b0, imm32}, 64'd0);
    chk({name, "_fmt"}, {58'b0, fmt32, fmt64}, 64'd0);
    chk({name, "_ill"}, {62'b0, ill32, ill64}, 64'd0);
    chk({name, "_tag"}, {48'b0, tag32, tag64}, 64'd0);
    chk({name, "_ready"}, {62'b0, ir32, ir64}, 64'd3);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed decode vectors
    direct("addi", 32'hFFF00093, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 3'd1);
    direct("beq",  32'hFE000EE3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 3'd3);
    direct("lui",  32'h80000037, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 3'd4);
    direct("srai", 32'h40205093, 64'd2, 64'd2, 3'd6, 3'd6);
    direct("op32", 32'h0000003B, 64'd0, 64'd0, 3'd7, 3'd0);
    direct("csr",  32'hFFF02073, 64'h0000_0FFF, 64'h0000_0000_0000_0FFF, 3'd1, 3'd1);
    drain();

    // Skid buffer fill and in-order release
    delivered.delete();
    out_ready = 1'b0;
    push_one(8'd1);
    push_one(8'd2);
    @(negedge clk);
    chk("skid_full_ready", 64'(ir32), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_tag   = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    begin
      bit done;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
        @(negedge clk);
        if (ir[0]) done = 1'b1;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      chk("tag3_accept", 64'(done), 64'd1);
    end
    drain();
    chk("order_count", 64'(delivered.size()), 64'd3);
    if (delivered.size() == 3) begin
      chk("order_0", 64'(delivered[0]), 64'd1);
      chk("order_1", 64'(delivered[1]), 64'd2);
      chk("order_2", 64'(delivered[2]), 64'd3);
    end

    // Flush with two entries held and a pending input
    delivered.delete();
    out_ready = 1'b0;
    push_one(8'd10);
    push_one(8'd11);
    in_valid = 1'b1;
    in_tag   = 8'd12;
    flush_i  = 1'b1;
    @(posedge clk);
    #1;
    flush_i  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {62'b0, ov32, ov64}, 64'd0);
    chk("flush_ready", {62'b0, ir32, ir64}, 64'd3);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("flush_no_emerge", 64'(delivered.size()), 64'd0);

    // Reset in the middle of backpressure
    out_ready = 1'b0;
    push_one(8'd20);
    push_one(8'd21);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    direct("post_reset", 32'h00500113, 64'd5, 64'd5, 3'd1, 3'd1);
    drain();

    // Random traffic with random backpressure and occasional flush
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_tag    = 8'($urandom());
      out_ready = ($urandom_range(0, 9) < 7);
      flush_i   = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      #1;
    end
    flush_i = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
